// File: rtl/arbitro_controlador.sv
// Round-robin arbiter that shares one serial controller among N_REQ requesters,
// launching each granted transfer and reporting done or watchdog timeout back to its owner.
module arbitro_controlador #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SLV_W   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ*SLV_W-1:0]    req_slave,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done_req,
  output logic [N_REQ-1:0]          err_req,
  output logic                      busy,
  output logic [DATA_W-1:0]         datain,
  output logic [SLV_W-1:0]          slave_numb,
  output logic                      ctrl_start,
  input  logic                      ctrl_done
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] last;
  logic [PTR_W-1:0] sel;
  logic [WD_W-1:0]  watchdog;

  logic [PTR_W-1:0] win_c;
  logic             found_c;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    onehot = N_REQ'(1) << i;
  endfunction

  // Winner: first set request bit scanning upward from the slot after the last grant.
  always_comb begin
    int unsigned idx;
    win_c   = last;
    found_c = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last) + k) % N_REQ;
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        win_c   = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= PTR_W'(N_REQ - 1);
      sel        <= '0;
      watchdog   <= '0;
      gnt        <= '0;
      done_req   <= '0;
      err_req    <= '0;
      busy       <= 1'b0;
      datain     <= '0;
      slave_numb <= '0;
      ctrl_start <= 1'b0;
    end else begin
      done_req <= '0;
      err_req  <= '0;
      case (state)
        IDLE: begin
          if (found_c) begin
            datain     <= req_data[32'(win_c)*DATA_W +: DATA_W];
            slave_numb <= req_slave[32'(win_c)*SLV_W +: SLV_W];
            gnt        <= onehot(win_c);
            ctrl_start <= 1'b1;
            last       <= win_c;
            sel        <= win_c;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          gnt        <= '0;
          ctrl_start <= 1'b0;
          watchdog   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          watchdog <= watchdog + WD_W'(1);
          // A completion on the final watchdog cycle still counts as success.
          if (ctrl_done) begin
            done_req <= onehot(sel);
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
            err_req <= onehot(sel);
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/arbitro_controlador.md
Name: arbitro_controlador

Overview:
- Round-robin arbiter and sequencer that shares one `controlador` (serial master driven by `datain[15:0]` and `slave_numb[1:0]`) among N_REQ requesters.
- Latches the winning requester's data word and slave number and issues a one-cycle start to the controller.
- Waits for the controller's completion, with a watchdog timeout, then reports done or error back to the owning requester.
- Sits between the requesting blocks and the controller.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, data word width, matches controller `datain`
- SLV_W, 2, slave-select width, matches controller `slave_numb`
- TIMEOUT, 64, maximum WAIT cycles before abort (>=2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  N_REQ  level request, one bit per requester
- req_data  input  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- req_slave  input  N_REQ*SLV_W  requester i slave at bits [i*SLV_W +: SLV_W]
- gnt  output  N_REQ  one-hot, one-cycle grant pulse
- done_req  output  N_REQ  one-hot, one-cycle completion pulse
- err_req  output  N_REQ  one-hot, one-cycle timeout pulse
- busy  output  1  high whenever state != IDLE
- datain  output  DATA_W  word to controller
- slave_numb  output  SLV_W  slave select to controller
- ctrl_start  output  1  one-cycle start pulse to controller
- ctrl_done  input  1  controller completion pulse

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high. All outputs are registered.
- Reset values: gnt=0, done_req=0, err_req=0, busy=0, datain=0, slave_numb=0, ctrl_start=0. State=IDLE, watchdog=0, rr pointer `last`=N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, LAUNCH, WAIT.
- IDLE, `req` nonzero at edge k:
  - Winner i is the first set bit searching last+1, last+2, ... modulo N_REQ.
  - At edge k: datain<=req_data[i], slave_numb<=req_slave[i], gnt<=onehot(i), ctrl_start<=1, last<=i, sel<=i, state<=LAUNCH.
  - `req` is sampled only in IDLE.
- LAUNCH: lasts exactly one cycle, during which gnt and ctrl_start are high. Next edge: gnt<=0, ctrl_start<=0, watchdog<=0, state<=WAIT. ctrl_done is ignored in LAUNCH.
- WAIT: watchdog increments each cycle.
  - ctrl_done=1: done_req<=onehot(sel), state<=IDLE.
  - Else if watchdog==TIMEOUT-1: err_req<=onehot(sel), state<=IDLE.
  - ctrl_done wins if it coincides with the timeout cycle.
- done_req and err_req clear one cycle after they assert. At most one of gnt, done_req, err_req is nonzero in any cycle.
- datain and slave_numb hold from grant until the next grant; they are stable for the whole transaction. Controller inputs never change while busy=1.
- ctrl_done in IDLE or LAUNCH is ignored; no pulse is generated.
- Requester protocol: hold req and its data/slave stable until gnt is seen, then drop req. req still high when the arbiter returns to IDLE is a new request.
- Back-to-back: a request present in the IDLE cycle after done or err is granted at that edge. Minimum period per transaction is 3 cycles (LAUNCH, ≥1 WAIT, IDLE).
- Fairness: a requester that is granted becomes lowest priority for the next arbitration. No requester waits more than N_REQ-1 grants.
- Reset mid-operation (LAUNCH or WAIT): return to IDLE with reset values next edge. No done_req or err_req is emitted, and the pointer is reinitialised.
- Width rules:
  - Watchdog width is clog2(TIMEOUT).
  - Pointer and sel width is clog2(N_REQ).
  - Pointer wraps N_REQ-1 -> 0.

Test Plan:
1. Single request: req=4'b0100, data[2]=16'hA5C3, slave[2]=2 -> next cycle gnt=4'b0100, ctrl_start=1, datain=16'hA5C3, slave_numb=2; ctrl_done 5 cycles later -> done_req=4'b0100 one cycle, busy falls.
2. Simultaneous requests: req=4'b1111 held, each dropped after its gnt, ctrl_done 3 cycles after each start -> grants in order 0,1,2,3; each done_req matches the preceding gnt.
3. Fairness: req[0] kept high permanently, req[3] asserted -> grants alternate 0,3,0,3; req[3] is never skipped.
4. Timeout: grant requester 1, ctrl_done never asserted -> err_req=4'b0010 exactly TIMEOUT (64) cycles after LAUNCH; no done_req; the next request is granted normally.
5. Spurious/coincident done:
   - ctrl_done in IDLE -> no outputs.
   - ctrl_done in the LAUNCH cycle -> ignored; transaction waits for a later done.
   - ctrl_done on the last watchdog cycle -> done_req, not err_req.
6. Reset mid-WAIT after grant to requester 2 -> next cycle all outputs 0, busy=0; no done_req/err_req; the next req=4'b1100 grants requester 2 (pointer reset).
